// File: rtl/bram_block_streamer.sv
// Streams NUM_BLOCKS blocks from a fixed-latency BRAM read port into a valid/ready stream.
// A credit check on reads in flight plus FIFO occupancy keeps the skid FIFO from overflowing.
module bram_block_streamer #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  output logic                          busy_out,
  output logic                          done_out,
  output logic                          read_next_out,
  input  logic [REGISTER_SIZE-1:0]      read_block_in,
  input  logic                          read_block_valid_in,
  output logic [REGISTER_SIZE-1:0]      block_out,
  output logic                          block_valid_out,
  input  logic                          block_ready_in,
  output logic                          block_last_out,
  output logic [$clog2(NUM_BLOCKS)-1:0] block_index_out
);

  localparam int IW = $clog2(NUM_BLOCKS);
  localparam int CW = IW + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = PW + 1;
  localparam int SW = FW + 1;

  localparam logic [CW-1:0] NB_C     = CW'(NUM_BLOCKS);
  localparam logic [CW-1:0] LAST_C   = CW'(NUM_BLOCKS - 1);
  localparam logic [SW-1:0] FD_C     = SW'(FIFO_DEPTH);
  localparam logic [FW-1:0] FCNT_MAX = FW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_MAX  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   req_cnt_q, req_cnt_d;
  logic [CW-1:0]   pop_cnt_q, pop_cnt_d;
  logic [FW-1:0]   inflight_q, inflight_d;
  logic [FW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            done_q, done_d;

  logic [REGISTER_SIZE-1:0] fifo_mem [FIFO_DEPTH];

  logic            fifo_valid;
  logic            push;
  logic            pop;
  logic            last_pop;
  logic            read_next;
  logic [SW-1:0]   credit_used;

  always_comb begin
    fifo_valid  = (fifo_cnt_q != '0);
    pop         = fifo_valid && block_ready_in;
    push        = read_block_valid_in && (state_q != IDLE);
    // A pop in this cycle frees its slot before the next request lands.
    credit_used = SW'(inflight_q) + SW'(fifo_cnt_q) - SW'(pop);
    read_next   = (state_q == STREAM) && (req_cnt_q < NB_C) && (credit_used < FD_C);
    last_pop    = pop && (pop_cnt_q == LAST_C);
  end

  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q + CW'(read_next);
    pop_cnt_d  = pop_cnt_q + CW'(pop);
    inflight_d = inflight_q + FW'(read_next) - FW'(push);
    fifo_cnt_d = fifo_cnt_q + FW'(push) - FW'(pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    done_d     = 1'b0;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d   = STREAM;
          req_cnt_d = '0;
          pop_cnt_d = '0;
        end
      end
      STREAM: begin
        if (req_cnt_d == NB_C) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      req_cnt_q  <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      done_q     <= done_d;
    end
  end

  // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= read_block_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      assert (!(push && !pop && (fifo_cnt_q == FCNT_MAX)));
      assert (!(read_block_valid_in && (state_q == IDLE)));
    end
  end

  assign busy_out        = (state_q != IDLE);
  assign done_out        = done_q;
  assign read_next_out   = read_next;
  assign block_valid_out = fifo_valid;
  assign block_out       = fifo_valid ? fifo_mem[rd_ptr_q] : '0;
  assign block_last_out  = fifo_valid && (pop_cnt_q == LAST_C);
  assign block_index_out = pop_cnt_q[IW-1:0];

endmodule

// File: tb/tb_bram_block_streamer.sv
// Directed and random checks of bram_block_streamer (8-block and 128-block instances)
// against a 2-cycle-latency BRAM model and an index scoreboard.
module tb_bram_block_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 8-block instance
  logic        st8, busy8, done8, rn8, rv8, bv8, rdy8, bl8;
  logic [31:0] rd8, bo8;
  logic [2:0]  bi8;

  // 128-block instance
  logic        st128, busy128, done128, rn128, rv128, bv128, rdy128, bl128;
  logic [31:0] rd128, bo128;
  logic [6:0]  bi128;

  bram_block_streamer #(.REGISTER_SIZE(32), .NUM_BLOCKS(8), .FIFO_DEPTH(4)) dut8 (
    .clk_in(clk), .rst_in(rst_n), .start_in(st8), .busy_out(busy8), .done_out(done8),
    .read_next_out(rn8), .read_block_in(rd8), .read_block_valid_in(rv8),
    .block_out(bo8), .block_valid_out(bv8), .block_ready_in(rdy8),
    .block_last_out(bl8), .block_index_out(bi8)
  );

  bram_block_streamer #(.REGISTER_SIZE(32), .NUM_BLOCKS(128), .FIFO_DEPTH(4)) dut128 (
    .clk_in(clk), .rst_in(rst_n), .start_in(st128), .busy_out(busy128), .done_out(done128),
    .read_next_out(rn128), .read_block_in(rd128), .read_block_valid_in(rv128),
    .block_out(bo128), .block_valid_out(bv128), .block_ready_in(rdy128),
    .block_last_out(bl128), .block_index_out(bi128)
  );

  // BRAM models: address advances on each request, data+valid appear two cycles later.
  logic [2:0]  a8;
  logic        v8a;
  logic [31:0] d8a;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a8 <= '0; v8a <= 1'b0; rv8 <= 1'b0; d8a <= '0; rd8 <= '0;
    end else begin
      v8a <= rn8;
      rv8 <= v8a;
      d8a <= 32'h100 + {29'b0, a8};
      rd8 <= d8a;
      if (rn8) a8 <= a8 + 3'd1;
    end
  end

  logic [6:0]  a128;
  logic        v128a;
  logic [31:0] d128a;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a128 <= '0; v128a <= 1'b0; rv128 <= 1'b0; d128a <= '0; rd128 <= '0;
    end else begin
      v128a <= rn128;
      rv128 <= v128a;
      d128a <= 32'h100 + {25'b0, a128};
      rd128 <= d128a;
      if (rn128) a128 <= a128 + 7'd1;
    end
  end

  int n_checks = 0;
  int n_fails  = 0;
  int rn8_cnt = 0, dn8_cnt = 0, rn128_cnt = 0, dn128_cnt = 0;
  int unsigned q8[$];
  int unsigned q128[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    int unsigned e;
    if (!rst_n) return;
    if (rn8)    rn8_cnt++;
    if (done8)  dn8_cnt++;
    if (rn128)  rn128_cnt++;
    if (done128) dn128_cnt++;
    if (bv8 && rdy8) begin
      if (q8.size() == 0) begin
        chk("sb8_extra_block", 32'(bv8), 32'd0);
      end else begin
        e = q8.pop_front();
        chk("sb8_data", bo8, 32'h100 + e);
        chk("sb8_index", 32'(bi8), e);
        chk("sb8_last", 32'(bl8), 32'(e == 7));
        $display("dut8   block idx %0d data 0x%0h last %0d", bi8, bo8, bl8);
      end
    end
    if (bv128 && rdy128) begin
      if (q128.size() == 0) begin
        chk("sb128_extra_block", 32'(bv128), 32'd0);
      end else begin
        e = q128.pop_front();
        chk("sb128_data", bo128, 32'h100 + e);
        chk("sb128_index", 32'(bi128), e);
        chk("sb128_last", 32'(bl128), 32'(e == 127));
        $display("dut128 block idx %0d data 0x%0h last %0d", bi128, bo128, bl128);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push8();
    for (int i = 0; i < 8; i++) q8.push_back(i);
  endtask

  initial begin
    int r0, d0, got;

    rst_n = 1'b0; st8 = 1'b0; st128 = 1'b0; rdy8 = 1'b1; rdy128 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_read_next", 32'(rn8), 32'd0);
    chk("rst_valid", 32'(bv8), 32'd0);
    chk("rst_block", bo8, 32'd0);
    chk("rst_index", 32'(bi8), 32'd0);
    chk("rst_last", 32'(bl8), 32'd0);
    chk("rst_valid128", 32'(bv128), 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Basic transfer, ready always high: exact cycle timing.
    push8();
    for (int c = 0; c < 14; c++) begin
      st8 = (c == 0);
      sample();
      chk("t1_read_next", 32'(rn8), 32'(c >= 1 && c <= 8));
      chk("t1_busy", 32'(busy8), 32'(c >= 1 && c <= 11));
      chk("t1_done", 32'(done8), 32'(c == 12));
      chk("t1_valid", 32'(bv8), 32'(c >= 4 && c <= 11));
      if (c >= 4 && c <= 11) chk("t1_data", bo8, 32'(32'h100 + c - 4));
      if (c == 11) chk("t1_last", 32'(bl8), 32'd1);
      tick();
    end
    st8 = 1'b0;
    chk("t1_queue_empty", 32'(q8.size()), 32'd0);

    // Backpressure: ready low cycles 5-14.
    r0 = rn8_cnt; d0 = dn8_cnt;
    push8();
    for (int c = 0; c < 40; c++) begin
      st8  = (c == 0);
      rdy8 = !(c >= 5 && c <= 14);
      sample();
      if (c >= 5 && c <= 14) begin
        chk("t2_hold_data", bo8, 32'h101);
        chk("t2_hold_valid", 32'(bv8), 32'd1);
        chk("t2_hold_index", 32'(bi8), 32'd1);
      end
      if (c >= 6 && c <= 14) chk("t2_stall_read", 32'(rn8), 32'd0);
      if (c == 15) chk("t2_resume_read", 32'(rn8), 32'd1);
      tick();
    end
    st8 = 1'b0; rdy8 = 1'b1;
    chk("t2_reads", 32'(rn8_cnt - r0), 32'd8);
    chk("t2_dones", 32'(dn8_cnt - d0), 32'd1);
    chk("t2_queue_empty", 32'(q8.size()), 32'd0);

    // Random ready on the 128-block instance.
    r0 = rn128_cnt; d0 = dn128_cnt; got = 0;
    for (int i = 0; i < 128; i++) q128.push_back(i);
    for (int c = 0; c < 2000 && got == 0; c++) begin
      st128  = (c == 0);
      rdy128 = 1'($urandom_range(0, 1));
      sample();
      if (done128) got = 1;
      tick();
    end
    st128 = 1'b0; rdy128 = 1'b1;
    chk("t3_timeout", 32'(got), 32'd1);
    repeat (5) begin sample(); tick(); end
    chk("t3_reads", 32'(rn128_cnt - r0), 32'd128);
    chk("t3_dones", 32'(dn128_cnt - d0), 32'd1);
    chk("t3_queue_empty", 32'(q128.size()), 32'd0);

    // start re-pulsed in STREAM (c3) and DRAIN (c9) is ignored.
    r0 = rn8_cnt; d0 = dn8_cnt;
    push8();
    for (int c = 0; c < 20; c++) begin
      st8 = (c == 0 || c == 3 || c == 9);
      sample();
      chk("t4_done", 32'(done8), 32'(c == 12));
      tick();
    end
    st8 = 1'b0;
    chk("t4_reads", 32'(rn8_cnt - r0), 32'd8);
    chk("t4_dones", 32'(dn8_cnt - d0), 32'd1);
    chk("t4_queue_empty", 32'(q8.size()), 32'd0);

    // Back-to-back: second start in the done_out cycle.
    r0 = rn8_cnt; d0 = dn8_cnt;
    push8(); push8();
    for (int c = 0; c < 30; c++) begin
      st8 = (c == 0 || c == 12);
      sample();
      chk("t5_done", 32'(done8), 32'(c == 12 || c == 24));
      if (c == 16) chk("t5_restart_index", 32'(bi8), 32'd0);
      tick();
    end
    st8 = 1'b0;
    chk("t5_reads", 32'(rn8_cnt - r0), 32'd16);
    chk("t5_dones", 32'(dn8_cnt - d0), 32'd2);
    chk("t5_queue_empty", 32'(q8.size()), 32'd0);

    // Asynchronous reset at cycle 6 of a transfer, then a clean transfer.
    d0 = dn8_cnt;
    push8();
    for (int c = 0; c < 6; c++) begin
      st8 = (c == 0);
      sample();
      if (c == 5) chk("t6_pre_valid", 32'(bv8), 32'd1);
      tick();
    end
    st8 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy8), 32'd0);
    chk("t6_rst_read_next", 32'(rn8), 32'd0);
    chk("t6_rst_valid", 32'(bv8), 32'd0);
    chk("t6_rst_block", bo8, 32'd0);
    chk("t6_rst_index", 32'(bi8), 32'd0);
    chk("t6_rst_done", 32'(done8), 32'd0);
    q8.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t6_no_done_after_abort", 32'(dn8_cnt - d0), 32'd0);
    r0 = rn8_cnt; d0 = dn8_cnt;
    push8();
    for (int c = 0; c < 16; c++) begin
      st8 = (c == 0);
      sample();
      chk("t6_done", 32'(done8), 32'(c == 12));
      if (c == 4) chk("t6_first_block", bo8, 32'h100);
      tick();
    end
    st8 = 1'b0;
    chk("t6_reads", 32'(rn8_cnt - r0), 32'd8);
    chk("t6_dones", 32'(dn8_cnt - d0), 32'd1);
    chk("t6_queue_empty", 32'(q8.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bram_block_streamer.md
Name: bram_block_streamer

Overview:
- Drains a block-addressed BRAM buffer (one read_next pulse per block, data back 2 cycles later with its own valid) into a valid/ready block stream with backpressure.
- Sits directly downstream of the BRAM block read port. Feeds serial bignum consumers (modular multiplier, output UART packer).
- Bounds in-flight reads with a credit counter so the fixed BRAM latency never overflows its internal skid FIFO.

Parameters:
- REGISTER_SIZE, 32: bits per block.
- NUM_BLOCKS, 128: blocks per transfer; equals the upstream buffer depth.
- FIFO_DEPTH, 4: skid FIFO entries; must be >= 3 to sustain 1 block/cycle.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- start_in  input  1  one-cycle pulse that begins a transfer of NUM_BLOCKS blocks.
- busy_out  output  1  high from the cycle after an accepted start until done_out.
- done_out  output  1  one-cycle pulse after the last block is accepted downstream.
- read_next_out  output  1  read request to the BRAM buffer; advances its read address.
- read_block_in  input  REGISTER_SIZE  BRAM read data.
- read_block_valid_in  input  1  BRAM read data valid, 2 cycles after the request.
- block_out  output  REGISTER_SIZE  stream data (FIFO head).
- block_valid_out  output  1  stream valid.
- block_ready_in  input  1  stream ready.
- block_last_out  output  1  high with the block at index NUM_BLOCKS-1.
- block_index_out  output  $clog2(NUM_BLOCKS)  index of the block on block_out.

Behaviour:
- Reset (rst_in low, async): all outputs 0, FSM to IDLE, all counters and the FIFO cleared. Reset mid-transfer aborts with no done_out. The system must reset the upstream buffer's address counter in the same cycle.
- FSM states: IDLE, STREAM, DRAIN.
- IDLE -> STREAM on start_in. start_in is ignored in STREAM and DRAIN.
- STREAM -> DRAIN when the request count reaches NUM_BLOCKS.
- DRAIN -> IDLE on the pop of the last block; done_out pulses the following cycle, with busy_out dropping in that same cycle.
- Request rule: read_next_out = (state == STREAM) && req_cnt < NUM_BLOCKS && (inflight + fifo_count - pop) < FIFO_DEPTH. The pop term is combinational and frees a credit in the same cycle.
- inflight: +1 per request, -1 per read_block_valid_in; both in one cycle leaves it unchanged.
- FIFO: push on read_block_valid_in; pop on block_valid_out && block_ready_in. Push and pop in the same cycle keeps the count unchanged. Overflow is impossible by the credit rule; an overflow is flagged by a simulation assertion.
- block_valid_out = FIFO non-empty. A pushed entry is visible the cycle after the push; no combinational path from read_block_in to block_out.
- Stream stability: block_out, block_index_out and block_last_out stay stable while valid && !ready.
- block_index_out: counts pops, 0..NUM_BLOCKS-1; resets to 0 at start.
- read_block_valid_in in IDLE is ignored (no push) and flagged by a simulation assertion.
- Latency with ready held high: start at cycle 0 -> read_next_out at cycle 1 -> read_block_valid_in at cycle 3 -> block_valid_out at cycle 4. Then one block per cycle; last block at cycle NUM_BLOCKS+3, done_out at NUM_BLOCKS+4.
- Back-to-back: a start arriving the cycle done_out is high is accepted.
- Width rules: req_cnt and pop count are $clog2(NUM_BLOCKS)+1 bits; inflight and fifo_count are $clog2(FIFO_DEPTH)+1 bits.

Test Plan:
- NUM_BLOCKS=8, BRAM model preloaded with data 0x100+i, ready always 1, start at cycle 0 -> read_next_out high cycles 1-8. Blocks 0x100..0x107 on cycles 4-11, last at 0x107, done_out at cycle 12, busy_out cycles 1-11.
- Same setup, ready low cycles 5-14 -> read_next_out stalls once inflight+fifo reaches 4. block_out holds 0x101 throughout the stall. No FIFO overflow; all 8 blocks in order; done_out after the last pop.
- Random ready (50%), NUM_BLOCKS=128 -> 128 blocks in index order, exactly 128 read_next pulses, exactly one done_out.
- start_in re-pulsed mid-transfer -> ignored; counts are unaffected.
- Second start in the done_out cycle -> second transfer completes with indices restarting at 0.
- rst_in low at cycle 6 of a transfer -> all outputs 0 immediately; after release, a new start streams 8 blocks correctly with the BRAM model reset too.
